// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, controller states and byte-lane helpers
// shared by the load/store controller and its alignment datapath.
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Byte lanes touched across two consecutive words; bits [7:4] are the second word.
    function automatic logic [7:0] byte_mask(input logic [1:0] size_code, input logic [1:0] off);
        logic [7:0] base;
        case (size_code)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] shl_bytes(input logic [63:0] v, input logic [1:0] off);
        return v << {off, 3'b000};
    endfunction

    function automatic logic [31:0] shr_bytes_lo(input logic [63:0] v, input logic [1:0] off);
        logic [63:0] t;
        t = v >> {off, 3'b000};
        return t[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane datapath -- mask, split detect,
// store-data placement and load-data merge/extension.
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [7:0]  mask,
    output logic        split,
    output logic [31:0] st_lo,
    output logic [31:0] st_hi,
    output logic [31:0] ld_data
);

    logic [63:0] st_wide;
    logic [31:0] raw;

    always_comb begin
        mask    = byte_mask(funct3[1:0], offset);
        split   = (mask > 8'h0F);
        st_wide = shl_bytes({32'h0, wdata}, offset);
        st_lo   = st_wide[31:0];
        st_hi   = st_wide[63:32];
        raw     = shr_bytes_lo({hi_word, lo_word}, offset);
        case (funct3)
            F3_B:    ld_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ld_data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ld_data = {24'h0, raw[7:0]};
            F3_HU:   ld_data = {16'h0, raw[15:0]};
            F3_W:    ld_data = raw;
            default: ld_data = raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store controller in front of a word-addressed data
// memory; splits word-crossing accesses into two beats and registers the response.
`default_nettype none

module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_fault,
    output logic [ADDR_BITS-3:0] mem_address,
    output logic [3:0]           mem_byteena,
    output logic [31:0]          mem_data,
    output logic                 mem_wren,
    input  logic [31:0]          mem_q
);

    localparam int WA_BITS = ADDR_BITS - 2;

    state_t               state, state_nxt;
    logic                 out_of_reset;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          lo_q;

    logic                 accept;
    logic [7:0]           req_mask;
    logic                 illegal_f3, out_of_range, wraps, fault_now;

    logic [7:0]           mask;
    logic                 split;
    logic [31:0]          st_lo, st_hi, ld_data;
    logic [31:0]          lo_word, hi_word;
    logic [WA_BITS-1:0]   word_addr;

    assign accept     = req_valid & req_ready;
    assign req_ready  = out_of_reset & (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign word_addr  = addr_q[ADDR_BITS-1:2];

    // Fault screening runs on the live request so a faulting access never issues a beat.
    always_comb begin
        req_mask = byte_mask(req_funct3[1:0], req_addr[1:0]);
        if (req_we)
            illegal_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            illegal_f3 = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        out_of_range = |req_addr[31:ADDR_BITS];
        wraps        = (req_mask > 8'h0F) & (&req_addr[ADDR_BITS-1:2]);
        fault_now    = illegal_f3 | out_of_range | wraps;
    end

    // During BEAT1 the first word comes from lo_q and the second is live on mem_q.
    assign lo_word = (state == ST_BEAT1) ? lo_q : mem_q;
    assign hi_word = (state == ST_BEAT1) ? mem_q : 32'h0;

    lsu_align u_align (
        .offset  (addr_q[1:0]),
        .funct3  (f3_q),
        .wdata   (wdata_q),
        .lo_word (lo_word),
        .hi_word (hi_word),
        .mask    (mask),
        .split   (split),
        .st_lo   (st_lo),
        .st_hi   (st_hi),
        .ld_data (ld_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            out_of_reset <= 1'b0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            resp_rdata   <= 32'h0;
            resp_fault   <= 1'b0;
        end else begin
            state        <= state_nxt;
            out_of_reset <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_BITS-1:0];
                wdata_q <= req_wdata;
            end
            if (state == ST_BEAT0)
                lo_q <= mem_q;
            if (accept && fault_now) begin
                resp_rdata <= 32'h0;
                resp_fault <= 1'b1;
            end else if (((state == ST_BEAT0) && !split) || (state == ST_BEAT1)) begin
                resp_rdata <= we_q ? 32'h0 : ld_data;
                resp_fault <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_address = '0;
        mem_byteena = 4'h0;
        mem_data    = 32'h0;
        mem_wren    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = fault_now ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                mem_address = word_addr;
                mem_byteena = mask[3:0];
                mem_data    = st_lo;
                mem_wren    = we_q;
                state_nxt   = split ? ST_BEAT1 : ST_RESP;
            end
            ST_BEAT1: begin
                mem_address = word_addr + WA_BITS'(1);
                mem_byteena = mask[7:4];
                mem_data    = st_hi;
                mem_wren    = we_q;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the data memory (word-addressed, 4 byte-enables, combinational read, write on posedge).
- Accepts byte-addressed RV32 load/store requests from the execute stage over a valid/ready handshake.
- Drives the memory's word address, byte enables, write data and write enable.
- Splits word-crossing misaligned accesses into two memory beats, merges and sign/zero-extends load data, and returns a registered response.

Parameters:
- ADDR_BITS, `DATA_BITS (config.sv): byte-address width of data memory; memory word address is ADDR_BITS-2 bits.

Ports:
- clock  in  1  single clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  illegal funct3 or address out of range
- mem_address  out  ADDR_BITS-2  memory word address
- mem_byteena  out  4  memory byte enables
- mem_data  out  32  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  32  memory read data, combinational from mem_address

Behaviour:
- Reset (async, reset_n=0): state=IDLE; resp_valid=0, resp_fault=0, resp_rdata=0, mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0. req_ready=1 once in IDLE.
- Handshake: a request is accepted on a posedge with req_valid&req_ready. All request fields are registered at acceptance and are don't-care afterwards.
- Response: resp_valid stays high with stable resp_rdata/resp_fault until resp_valid&resp_ready. No new request is accepted until then.
- Size: funct3[1:0] gives size s = 1/2/4 bytes. Offset o = addr[1:0]. Byte mask m = ((1<<s)-1)<<o, 8 bits wide.
- Split: an access is split iff m[7:4] != 0.
- Fault is decided at acceptance and causes no memory beats. Fault conditions:
  - load funct3 in {011,110,111};
  - store funct3 >= 011;
  - req_addr >= 2**ADDR_BITS;
  - split access whose second word index would equal 2**(ADDR_BITS-2), i.e. wrap at the top.
- States: IDLE, BEAT0, BEAT1, RESP.
  - IDLE -> BEAT0 on accept with no fault.
  - IDLE -> RESP on accept with fault.
  - BEAT0 -> BEAT1 if split, else RESP.
  - BEAT1 -> RESP.
  - RESP -> IDLE on resp_ready.
- BEAT0 outputs: mem_address = addr[ADDR_BITS-1:2]; mem_byteena = m[3:0]; mem_data = low word of (64-bit zero-extended wdata << 8*o); mem_wren = we.
- BEAT1 outputs: mem_address = addr word + 1; mem_byteena = m[7:4]; mem_data = high word of the same shift; mem_wren = we.
- Outside BEAT0/BEAT1: mem_wren=0 and mem_byteena=0.
- Loads: mem_q is captured at the end of BEAT0 into lo and at the end of BEAT1 into hi (hi=0 if not split). The result is ({hi,lo} >> 8*o)[31:0], extended per funct3: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. It is registered into resp_rdata on entry to RESP.
- Latency, accept edge to resp_valid high: aligned or non-split = 2 cycles, split = 3 cycles, fault = 1 cycle.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_wren drops asynchronously. A split store interrupted after BEAT0 leaves the first word written; this is accepted behaviour.
- Arithmetic: offset shift is done in 64 bits; word-index increment is ADDR_BITS-2 bits wide and never wraps, because wrap is a fault.

Decomposition:
- lsu_pkg: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101); state enum; size/mask helper function; 64-bit shift helper.
- One sub-module, lsu_align: purely combinational. Computes byte mask, split flag, shifted store words and the extended load result. The FSM stays in lsu_mem_ctrl.

Test Plan:
- Reset: hold reset_n=0 -> all outputs 0 and req_ready=0 in reset; release -> req_ready=1, resp_valid=0.
- SW 0x11223344 @0x10, then LW @0x10 -> one beat each; store beat has mem_byteena=1111 and mem_address=4; load gives resp_rdata=0x11223344 at accept+2.
- SB 0x000000F0 @0x13, LB @0x13 -> store beat has byteena=1000, mem_data=0xF0000000; LB returns 0xFFFFFFF0 and LBU @0x13 returns 0x000000F0.
- SW 0xAABBCCDD @0x0E (split) -> BEAT0 addr=3 byteena=1100 data=0xCCDD0000; BEAT1 addr=4 byteena=0011 data=0x0000AABB; LW @0x0E returns 0xAABBCCDD at accept+3.
- Faults: funct3=011 load, SW @2**ADDR_BITS, and LW @2**ADDR_BITS-2 (wrap) -> resp_fault=1 and resp_rdata=0 at accept+1; mem_wren never asserted.
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> response stable and req_ready=0. Pulse reset_n low during BEAT1 of a split store -> mem_wren drops the same cycle, state IDLE, no response emitted.
